// File: rtl/seq_divider_pkg.sv
// Shared datapath definitions for the sequential signed divider.
// Holds FSM state encodings, the datapath width and the iteration count.
package seq_divider_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DIV_ITERS  = DATA_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } div_state_t;

endpackage

// File: rtl/seq_divider_twos_negate.sv
// Combinational conditional two's-complement negate.
// Used for operand magnitudes and for the final sign correction.
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Negate when enabled, otherwise pass through
    always_comb begin
        if (en) begin
            y = (~a) + WIDTH'(1);
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per cycle,
// sign correction in a separate FIX step, all outputs registered.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    div_state_t       state_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] rem_r;
    logic             sign_dvd_r;
    logic             sign_dsr_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dsr_mag_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] dvd_next_s;
    logic             divisor_zero_s;

    twos_negate #(.WIDTH(WIDTH)) u_neg_dvd (
        .en (dividend[WIDTH-1]),
        .a  (dividend),
        .y  (dvd_mag_s)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_dsr (
        .en (divisor[WIDTH-1]),
        .a  (divisor),
        .y  (dsr_mag_s)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_quot (
        .en (sign_dvd_r ^ sign_dsr_r),
        .a  (dvd_r),
        .y  (q_fix_s)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .en (sign_dvd_r),
        .a  (rem_r),
        .y  (r_fix_s)
    );

    // One restoring step; quotient bits shift into the vacated dividend LSBs
    always_comb begin
        divisor_zero_s = (divisor == {WIDTH{1'b0}});
        shifted_s      = {rem_r, dvd_r[WIDTH-1]};
        diff_s         = shifted_s - {1'b0, dsr_r};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_next_s = diff_s[WIDTH-1:0];
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end
        dvd_next_s = {dvd_r[WIDTH-2:0], ~diff_s[WIDTH]};
    end

    // FSM, iteration counter, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r     <= IDLE;
            dvd_r       <= {WIDTH{1'b0}};
            dsr_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            sign_dvd_r  <= 1'b0;
            sign_dsr_r  <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r <= 1'b1;
                        if (divisor_zero_s) begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                            done_r      <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            dvd_r      <= dvd_mag_s;
                            dsr_r      <= dsr_mag_s;
                            sign_dvd_r <= dividend[WIDTH-1];
                            sign_dsr_r <= divisor[WIDTH-1];
                            rem_r      <= {WIDTH{1'b0}};
                            cnt_r      <= {CW{1'b0}};
                            dbz_r      <= 1'b0;
                            state_r    <= RUN;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    rem_r <= rem_next_s;
                    dvd_r <= dvd_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIX: begin
                    quotient_r  <= q_fix_s;
                    remainder_r <= r_fix_s;
                    done_r      <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;

endmodule
